mac_acc_seq: RTL
================

# mac_acc_seq

Command-driven sequencer for the MAC accumulator. It accepts a command carrying an initial value and an operand count. It loads the accumulator, streams exactly that many operands into it through a valid/ready port, and then presents the final sum on a valid/ready result port. It sits between the MAC issue logic and the accumulator, which has no enable of its own, so the sequencer owns the accumulator's load and gating.

## Interface
- ACC_W, default `MAC_ACC_WIDTH: accumulator and operand width.
- LEN_W, default 8: width of the operand count.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command can be taken. High only in IDLE.
- cmd_len  in  LEN_W  number of operands, 0 to 2^LEN_W-1.
- cmd_init  in  ACC_W  starting accumulator value.
- op_valid  in  1  operand offered.
- op_ready  out  1  operand can be taken. High only in ACCUM.
- op_data  in  ACC_W  operand to be added.
- res_valid  out  1  result available. High only in DONE.
- res_ready  in  1  consumer takes the result.
- res_data  out  ACC_W  accumulator value. Valid while res_valid is high.
- busy  out  1  high whenever state is not IDLE.
- stall_cycles  out  16  stall counter. Present only with MAC_SEQ_STALL_CNT_EN.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset state is IDLE.
- Accumulator load pulse: acc_load = reset | (cmd_valid & cmd_ready).
  - The load value is 0 when reset is high, otherwise cmd_init.
- Accumulator input: din = op_data when op_valid & op_ready, otherwise 0. An idle cycle therefore never changes the sum.
- IDLE:
  - On command handshake, latch cmd_len into the remaining counter.
  - Go to ACCUM if cmd_len != 0, otherwise go to DONE.
- ACCUM:
  - Each accepted beat decrements the remaining counter.
  - The beat that brings the counter to 0 moves the FSM to DONE.
- DONE:
  - res_data = accumulator.
  - res_valid is held, with res_data stable, until res_ready. Then go to IDLE.
- Arithmetic: sum modulo 2^ACC_W, wrapping with no overflow flag. Operands are treated as unsigned bit patterns; two's-complement values wrap correctly.
- Operand beats offered in IDLE or DONE are not accepted: op_ready is 0.
- Reset mid-operation:
  - Pending command is abandoned and the FSM returns to IDLE.
  - Accumulator is 0 and res_valid is 0 the next cycle.
- A new command cannot be accepted in the cycle a result is taken. cmd_ready rises the cycle after.

## Timing
- Output values after reset: cmd_ready=1, op_ready=0, res_valid=0, res_data=0, busy=0, stall_cycles=0.
- Command accepted at cycle t0 with len N > 0 and op_valid held high:
  - Beats are accepted at t0+1 through t0+N.
  - res_valid rises at t0+N+1.
  - With res_ready high, the FSM is back in IDLE at t0+N+2.
- len = 0: res_valid at t0+1, with res_data = cmd_init.
- Throughput: one operand per cycle in ACCUM.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input valid or ready to an output.

## Configuration
- MAC_SEQ_STALL_CNT_EN defined:
  - stall_cycles port exists.
  - It counts cycles in ACCUM with op_valid=0, plus cycles in DONE with res_ready=0.
  - It clears to 0 on each command handshake and on reset, and saturates at 16'hFFFF.
- Not defined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package: FSM state encoding (2-bit typedef: IDLE, ACCUM, DONE) and the stall counter width constant (16).
- ACC_W is taken from the existing `MAC_ACC_WIDTH constant.
- One sub-module: a single instance of the existing `accumulate` block.
  - reset is driven by acc_load and init_val by the load mux.
  - din is the gated operand; en is tied to 1.
- FSM, remaining counter and stall counter live in mac_acc_seq.

## Test plan
- Basic sum: reset, then cmd init=10, len=3; ops 1,2,3 back-to-back -> res_valid at t0+4 with res_data=16; busy low at t0+5.
- Zero length: cmd init=0x55, len=0 -> res_valid at t0+1 with res_data=0x55, and no op beat accepted.
- Gaps and backpressure: len=4, op_valid toggling 1/0 -> sum is correct; res_ready held low for 5 cycles -> res_data stable; with the macro defined, stall_cycles = operand gaps + 5.
- Wrap-around: ACC_W=16, init=0xFFFF, ops 1,1 -> res_data=0x0001.
- Reset mid-operation: assert reset after 2 of 5 beats -> next cycle IDLE, res_valid=0, cmd_ready=1; a following cmd init=0, len=1, op=7 -> result 7.
- Stray traffic: op_valid high in IDLE and DONE, and cmd_valid high in ACCUM -> none accepted; sum unaffected.

Source files
------------

// File: rtl/mac_acc_seq_pkg.sv
// Shared types and constants for the MAC accumulator sequencer.
// Provides a default for `MAC_ACC_WIDTH when the surrounding build has not set one.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 16
`endif

package mac_acc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    localparam int STALL_W = 16;

endpackage

// File: rtl/accumulate.sv
// Running-sum register: load init_val on reset, otherwise add din when en is high.
// Addition wraps modulo 2^W.
module accumulate #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] init_val,
    input  logic [W-1:0] din,
    input  logic         en,
    output logic [W-1:0] acc
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = acc_q + din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= init_val;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/mac_acc_seq.sv
// Command-driven sequencer owning the accumulator's load and operand gating.
// Optional stall counter port enabled by defining MAC_SEQ_STALL_CNT_EN.
module mac_acc_seq
    import mac_acc_seq_pkg::*;
#(
    parameter int ACC_W = `MAC_ACC_WIDTH,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [ACC_W-1:0] cmd_init,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [ACC_W-1:0] op_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             busy
`ifdef MAC_SEQ_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0] stall_cycles
`endif
);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic             cmd_hs;
    logic             op_hs;
    logic             res_hs;
    logic             acc_load;
    logic [ACC_W-1:0] acc_init;
    logic [ACC_W-1:0] acc_din;
    logic [ACC_W-1:0] acc_val;

    // Handshake outputs decode registered state only, so no input-to-output path exists.
    assign cmd_ready = (state_q == ST_IDLE);
    assign op_ready  = (state_q == ST_ACCUM);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_data  = acc_val;

    assign cmd_hs = cmd_valid & cmd_ready;
    assign op_hs  = op_valid & op_ready;
    assign res_hs = res_valid & res_ready;

    // The accumulator has no enable, so idle cycles feed it zero instead.
    assign acc_load = reset | cmd_hs;
    assign acc_init = reset ? '0 : cmd_init;
    assign acc_din  = op_hs ? op_data : '0;

    accumulate #(
        .W(ACC_W)
    ) u_acc (
        .clk      (clk),
        .reset    (acc_load),
        .init_val (acc_init),
        .din      (acc_din),
        .en       (1'b1),
        .acc      (acc_val)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    rem_d   = cmd_len;
                    state_d = (cmd_len != '0) ? ST_ACCUM : ST_DONE;
                end
            end
            ST_ACCUM: begin
                if (op_hs) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

`ifdef MAC_SEQ_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               stall_evt;

    assign stall_evt = ((state_q == ST_ACCUM) && !op_valid) ||
                       ((state_q == ST_DONE)  && !res_ready);

    always_comb begin
        stall_d = stall_q;
        if (cmd_hs) begin
            stall_d = '0;
        end else if (stall_evt && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
